rvfi_complete_monitor: RTL



---
 rtl/rvfi_complete_monitor_if.sv | 38 +++
 rtl/rvfi_complete_monitor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rvfi_complete_monitor_if.sv
// Retire-lane / spec-decode bundle observed by rvfi_complete_monitor, plus its result flags.
interface rvfi_complete_monitor_if #(
  parameter int NRET  = 1,
  parameter int ILEN  = 32,
  parameter int CNT_W = 32
);
  localparam int LW = (NRET > 1) ? $clog2(NRET) : 1;

  logic [NRET-1:0]           rvfi_valid;
  logic [NRET-1:0][63:0]     rvfi_order;
  logic [NRET-1:0][ILEN-1:0] rvfi_insn;
  logic [NRET-1:0]           rvfi_trap;
  logic [NRET-1:0]           spec_valid;
  logic [NRET-1:0]           spec_trap;
  logic                      chk_en;

  logic                      err_incomplete;
  logic                      err_order;
  logic                      err_wdog;
  logic                      fail;
  logic [LW-1:0]             fail_lane;
  logic [ILEN-1:0]           fail_insn;
  logic [63:0]               fail_order;
  logic [CNT_W-1:0]          retired_cnt;
  logic [CNT_W-1:0]          checked_cnt;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, spec_valid, spec_trap, chk_en,
    input  err_incomplete, err_order, err_wdog, fail, fail_lane, fail_insn, fail_order,
           retired_cnt, checked_cnt
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, spec_valid, spec_trap, chk_en,
    output err_incomplete, err_order, err_wdog, fail, fail_lane, fail_insn, fail_order,
           retired_cnt, checked_cnt
  );
endinterface

// File: rtl/rvfi_complete_monitor.sv
// Multi-lane RVFI completeness / retire-order / starvation monitor with sticky first-failure capture.
module rvfi_complete_monitor_lane #(
  parameter int         ILEN        = 32,
  parameter logic [6:0] EXCL_OPCODE = 7'b1110011
) (
  input  logic            valid_i,
  input  logic            prev_valid_i,
  input  logic [63:0]     order_i,
  input  logic [63:0]     exp_order_i,
  input  logic [ILEN-1:0] insn_i,
  input  logic            trap_i,
  input  logic            spec_valid_i,
  input  logic            spec_trap_i,
  input  logic            chk_en_i,
  output logic            chk_o,
  output logic            err_cmp_o,
  output logic            err_ord_o
);
  assign chk_o     = valid_i & ~trap_i & chk_en_i & (insn_i[6:0] != EXCL_OPCODE);
  assign err_cmp_o = chk_o & ~(spec_valid_i & ~spec_trap_i);
  assign err_ord_o = valid_i & (~prev_valid_i | (order_i != exp_order_i));
endmodule

module rvfi_complete_monitor #(
  parameter int         NRET        = 1,
  parameter int         ILEN        = 32,
  parameter int         CNT_W       = 32,
  parameter int         WDOG_CYCLES = 64,
  parameter logic [6:0] EXCL_OPCODE = 7'b1110011
) (
  input  logic                    clk,
  input  logic                    reset,
  rvfi_complete_monitor_if.slave  bus
);
  localparam int LW   = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int PW   = $clog2(NRET + 1);
  localparam int SW   = CNT_W + 1;
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_FAIL} state_e;

  state_e           state_q, state_d;
  logic             inc_q, inc_d, ord_q, ord_d, wdg_q, wdg_d, fail_q, fail_d;
  logic [LW-1:0]    lane_q, lane_d;
  logic [ILEN-1:0]  insn_q, insn_d;
  logic [63:0]      forder_q, forder_d;
  logic [CNT_W-1:0] ret_q, ret_d, chk_q, chk_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [63:0]      exp_q, exp_d;

  logic                  active, any_vld, wd_hit, lane_err_any;
  logic [63:0]           base;
  logic [NRET-1:0]       prev_vld, lchk, lcmp, lord, lerr;
  logic [NRET-1:0][63:0] exp_lane;
  logic [PW-1:0]         n_ret, n_chk;
  logic [LW-1:0]         first_lane;
  logic [ILEN-1:0]       first_insn;
  logic [63:0]           first_order;

  function automatic logic [CNT_W-1:0] sat_add(logic [CNT_W-1:0] a, logic [PW-1:0] b);
    logic [SW-1:0] s;
    s = {1'b0, a} + SW'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign active   = (state_q == S_ARMED) || (state_q == S_RUN);
  assign any_vld  = |bus.rvfi_valid;
  // First retire after arming defines the order baseline, so lane0 of that cycle always matches.
  assign base     = (state_q == S_ARMED && any_vld) ? bus.rvfi_order[0] : exp_q;
  assign prev_vld = NRET'({bus.rvfi_valid, 1'b1});

  for (genvar i = 0; i < NRET; i++) begin : g_lane
    assign exp_lane[i] = base + 64'(i);
    rvfi_complete_monitor_lane #(.ILEN(ILEN), .EXCL_OPCODE(EXCL_OPCODE)) u_lane (
      .valid_i      (bus.rvfi_valid[i]),
      .prev_valid_i (prev_vld[i]),
      .order_i      (bus.rvfi_order[i]),
      .exp_order_i  (exp_lane[i]),
      .insn_i       (bus.rvfi_insn[i]),
      .trap_i       (bus.rvfi_trap[i]),
      .spec_valid_i (bus.spec_valid[i]),
      .spec_trap_i  (bus.spec_trap[i]),
      .chk_en_i     (bus.chk_en),
      .chk_o        (lchk[i]),
      .err_cmp_o    (lcmp[i]),
      .err_ord_o    (lord[i])
    );
  end

  assign lerr         = active ? (lcmp | lord) : '0;
  assign lane_err_any = |lerr;
  assign wd_hit       = (WDOG_CYCLES != 0) && active && !any_vld && (wd_q == WD_MAX);

  always_comb begin
    n_ret       = '0;
    n_chk       = '0;
    first_lane  = '0;
    first_insn  = '0;
    first_order = '0;
    for (int i = 0; i < NRET; i++) begin
      n_ret = n_ret + PW'(bus.rvfi_valid[i]);
      n_chk = n_chk + PW'(lchk[i]);
    end
    for (int i = NRET - 1; i >= 0; i--) begin
      if (lerr[i]) begin
        first_lane  = LW'(i);
        first_insn  = bus.rvfi_insn[i];
        first_order = bus.rvfi_order[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      inc_q    <= 1'b0;
      ord_q    <= 1'b0;
      wdg_q    <= 1'b0;
      fail_q   <= 1'b0;
      lane_q   <= '0;
      insn_q   <= '0;
      forder_q <= '0;
      ret_q    <= '0;
      chk_q    <= '0;
      wd_q     <= '0;
      exp_q    <= '0;
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      ord_q    <= ord_d;
      wdg_q    <= wdg_d;
      fail_q   <= fail_d;
      lane_q   <= lane_d;
      insn_q   <= insn_d;
      forder_q <= forder_d;
      ret_q    <= ret_d;
      chk_q    <= chk_d;
      wd_q     <= wd_d;
      exp_q    <= exp_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    inc_d    = inc_q;
    ord_d    = ord_q;
    wdg_d    = wdg_q;
    fail_d   = fail_q;
    lane_d   = lane_q;
    insn_d   = insn_q;
    forder_d = forder_q;
    ret_d    = ret_q;
    chk_d    = chk_q;
    wd_d     = wd_q;
    exp_d    = exp_q;
    case (state_q)
      S_IDLE:  state_d = S_ARMED;
      S_ARMED: if (lane_err_any || wd_hit) state_d = S_FAIL;
               else if (any_vld)           state_d = S_RUN;
      S_RUN:   if (lane_err_any || wd_hit) state_d = S_FAIL;
      default: state_d = state_q;
    endcase
    if (active) begin
      ret_d = sat_add(ret_q, n_ret);
      chk_d = sat_add(chk_q, n_chk);
      wd_d  = any_vld ? '0 : wd_q + 1'b1;
      if (lane_err_any) begin
        inc_d    = |(lerr & lcmp);
        ord_d    = |(lerr & lord);
        fail_d   = 1'b1;
        lane_d   = first_lane;
        insn_d   = first_insn;
        forder_d = first_order;
      end else if (wd_hit) begin
        wdg_d    = 1'b1;
        fail_d   = 1'b1;
        lane_d   = '0;
        insn_d   = '0;
        forder_d = exp_q;
      end else begin
        exp_d = base + 64'(n_ret);
      end
    end
  end

  always_comb begin
    bus.err_incomplete = inc_q;
    bus.err_order      = ord_q;
    bus.err_wdog       = wdg_q;
    bus.fail           = fail_q;
    bus.fail_lane      = lane_q;
    bus.fail_insn      = insn_q;
    bus.fail_order     = forder_q;
    bus.retired_cnt    = ret_q;
    bus.checked_cnt    = chk_q;
  end
endmodule
